// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-timing helper and
// default clocking constants for the rx and tx sides.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE   = 115_200;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // System clocks per serial bit, truncated towards zero.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                    input int unsigned baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for signals entering the clk_i domain.
// Each bit resets to RESET_VAL so an idle-high line does not look active.
module sync_2ff #(
  parameter int unsigned WIDTH     = 1,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        meta_reg[gi] <= RESET_VAL;
        sync_reg[gi] <= RESET_VAL;
      end else begin
        meta_reg[gi] <= d_i[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q_o = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of the synchronised line, optional parity,
// one-entry output buffer with valid/ready handshake and overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned BAUD_RATE   = DEFAULT_BAUD_RATE,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             ODD      = (PARITY_ODD != 0);
  localparam logic             HAS_PAR  = (PARITY_EN != 0);

  if (CLKS_PER_BIT < 4) begin : g_bad_timing
    $error("uart_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_rx: DATA_BITS must be in 5..9");
  end

  logic rx_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  rx_state_e            state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 frame_par_err_reg;

  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 frame_err_reg;
  logic                 parity_err_reg;
  logic                 overrun_reg;

  logic                 bit_done;
  logic                 frame_done;
  logic                 can_load;
  logic [DATA_BITS-1:0] bit_sel;
  logic [DATA_BITS-1:0] shift_next;

  assign bit_done   = (cnt_reg == CNT_LAST);
  assign frame_done = (state_reg == RX_STOP) && bit_done;
  assign can_load   = !valid_reg || ready_i;

  // One-hot write enable for the data bit currently being sampled.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
    assign bit_sel[gi] = (idx_reg == IDX_W'(gi));
  end

  assign shift_next = (shift_reg & ~bit_sel) | (bit_sel & {DATA_BITS{rx_s}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= RX_IDLE;
      cnt_reg           <= '0;
      idx_reg           <= '0;
      shift_reg         <= '0;
      frame_par_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        RX_IDLE: begin
          if (!rx_s) begin
            state_reg <= RX_START;
            cnt_reg   <= '0;
          end
        end

        RX_START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg           <= '0;
            idx_reg           <= '0;
            frame_par_err_reg <= 1'b0;
            // A start bit that is high again at mid-bit was only a glitch.
            state_reg         <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            shift_reg <= shift_next;
            if (idx_reg == IDX_LAST) begin
              state_reg <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RX_PARITY: begin
          if (bit_done) begin
            cnt_reg           <= '0;
            frame_par_err_reg <= ((^shift_reg) ^ rx_s) != ODD;
            state_reg         <= RX_STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            // A low stop bit may be a break; wait for the line to recover.
            state_reg <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RX_WAIT_HIGH: begin
          if (rx_s) begin
            state_reg <= RX_IDLE;
          end
        end

        default: begin
          state_reg <= RX_IDLE;
        end
      endcase
    end
  end

  // Output buffer: a completed frame replaces the held one only if the held
  // one is absent or being consumed in the same cycle; otherwise it is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (frame_done) begin
        if (can_load) begin
          data_reg       <= shift_reg;
          frame_err_reg  <= ~rx_s;
          parity_err_reg <= frame_par_err_reg;
          valid_reg      <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_o       = data_reg;
  assign valid_o      = valid_reg;
  assign frame_err_o  = frame_err_reg;
  assign parity_err_o = parity_err_reg;
  assign overrun_o    = overrun_reg;
  assign busy_o       = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance (a) and an 8E1 instance (b)
// at 10 clocks per bit, checked against hand-computed expectations.
module tb_uart_rx;

  localparam int unsigned CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       rx_a = 1'b1, ready_a = 1'b1;
  logic [7:0] data_a;
  logic       valid_a, ferr_a, perr_a, ovr_a, busy_a;

  logic       rx_b = 1'b1, ready_b = 1'b1;
  logic [7:0] data_b;
  logic       valid_b, ferr_b, perr_b, ovr_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  int         acc_a = 0, ovr_cyc_a = 0, busy_cyc_a = 0, rise_cyc_a = 0;
  logic [7:0] last_data_a = '0;
  logic       last_ferr_a = 1'b0, last_perr_a = 1'b0, valid_a_q = 1'b0;
  int         acc_b = 0;
  logic [7:0] last_data_b = '0;
  logic       last_ferr_b = 1'b0, last_perr_b = 1'b0;

  uart_rx #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000),
    .DATA_BITS   (8),
    .PARITY_EN   (0),
    .PARITY_ODD  (0)
  ) dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_i         (rx_a),
    .data_o       (data_a),
    .valid_o      (valid_a),
    .ready_i      (ready_a),
    .frame_err_o  (ferr_a),
    .parity_err_o (perr_a),
    .overrun_o    (ovr_a),
    .busy_o       (busy_a)
  );

  uart_rx #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000),
    .DATA_BITS   (8),
    .PARITY_EN   (1),
    .PARITY_ODD  (0)
  ) dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_i         (rx_b),
    .data_o       (data_b),
    .valid_o      (valid_b),
    .ready_i      (ready_b),
    .frame_err_o  (ferr_b),
    .parity_err_o (perr_b),
    .overrun_o    (ovr_b),
    .busy_o       (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Record handshakes and pulse activity away from the active edge.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      acc_a       <= acc_a + 1;
      last_data_a <= data_a;
      last_ferr_a <= ferr_a;
      last_perr_a <= perr_a;
      $display("[%0t] a: accepted data=%02h frame_err=%0d parity_err=%0d", $time, data_a, ferr_a, perr_a);
    end
    if (valid_a && !valid_a_q) rise_cyc_a <= cycle_cnt;
    valid_a_q <= valid_a;
    if (ovr_a) ovr_cyc_a <= ovr_cyc_a + 1;
    if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
    if (valid_b && ready_b) begin
      acc_b       <= acc_b + 1;
      last_data_b <= data_b;
      last_ferr_b <= ferr_b;
      last_perr_b <= perr_b;
      $display("[%0t] b: accepted data=%02h frame_err=%0d parity_err=%0d", $time, data_b, ferr_b, perr_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input bit to_b, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop);
    $display("[%0t] %s: send data=%02h par=%0d/%0d stop=%0d", $time, to_b ? "b" : "a",
             d, has_par, par, stop);
    set_rx(to_b, 1'b0);
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      set_rx(to_b, d[i]);
      cyc(CPB);
    end
    if (has_par) begin
      set_rx(to_b, par);
      cyc(CPB);
    end
    set_rx(to_b, stop);
    cyc(CPB);
  endtask

  int acc0, ovr0, busy0, start_cyc;
  logic [7:0] partial;

  initial begin
    cyc(3);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_ferr", ferr_a, 0);
    check("rst_perr", perr_a, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    cyc(5);

    // Basic frame with the consumer always ready.
    acc0 = acc_a;
    start_cyc = cycle_cnt;
    send_frame(0, 8'hA5, 0, 0, 1);
    cyc(5);
    check("a5_count", acc_a - acc0, 1);
    check("a5_data", last_data_a, 8'hA5);
    check("a5_ferr", last_ferr_a, 0);
    check("a5_perr", last_perr_a, 0);
    check("a5_latency", rise_cyc_a - start_cyc, 98);
    check("a5_valid_low", valid_a, 0);
    check("a5_busy_low", busy_a, 0);

    // Short low glitch: five START cycles then back to idle, no frame.
    acc0 = acc_a;
    busy0 = busy_cyc_a;
    rx_a = 1'b0;
    cyc(3);
    rx_a = 1'b1;
    cyc(15);
    check("glitch_busy_cycles", busy_cyc_a - busy0, 5);
    check("glitch_no_frame", acc_a - acc0, 0);
    check("glitch_busy_low", busy_a, 0);
    send_frame(0, 8'h5A, 0, 0, 1);
    cyc(5);
    check("5a_count", acc_a - acc0, 1);
    check("5a_data", last_data_a, 8'h5A);

    // Framing error followed by a held break.
    acc0 = acc_a;
    send_frame(0, 8'h3C, 0, 0, 0);
    cyc(50);
    check("brk_count", acc_a - acc0, 1);
    check("brk_data", last_data_a, 8'h3C);
    check("brk_ferr", last_ferr_a, 1);
    check("brk_busy_wait", busy_a, 1);
    rx_a = 1'b1;
    cyc(10);
    check("brk_busy_low", busy_a, 0);
    check("brk_no_second", acc_a - acc0, 1);
    send_frame(0, 8'h55, 0, 0, 1);
    cyc(5);
    check("55_count", acc_a - acc0, 2);
    check("55_data", last_data_a, 8'h55);
    check("55_ferr", last_ferr_a, 0);

    // Overrun: second frame arrives while the first is still held.
    acc0 = acc_a;
    ovr0 = ovr_cyc_a;
    ready_a = 1'b0;
    send_frame(0, 8'h11, 0, 0, 1);
    cyc(5);
    check("ovr_valid_first", valid_a, 1);
    check("ovr_data_first", data_a, 8'h11);
    send_frame(0, 8'h22, 0, 0, 1);
    cyc(5);
    check("ovr_pulse_cycles", ovr_cyc_a - ovr0, 1);
    check("ovr_valid_held", valid_a, 1);
    check("ovr_data_held", data_a, 8'h11);
    ready_a = 1'b1;
    cyc(1);
    ready_a = 1'b0;
    check("ovr_valid_drop", valid_a, 0);
    check("ovr_accept_one", acc_a - acc0, 1);
    check("ovr_accept_data", last_data_a, 8'h11);
    ready_a = 1'b1;
    cyc(20);
    check("ovr_22_lost", acc_a - acc0, 1);

    // Reset in the middle of data bit 4 with a frame still buffered.
    ready_a = 1'b0;
    send_frame(0, 8'h33, 0, 0, 1);
    cyc(5);
    check("mid_held_valid", valid_a, 1);
    acc0 = acc_a;
    partial = 8'h81;
    rx_a = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 5; i++) begin
      rx_a = partial[i];
      cyc((i == 4) ? CPB / 2 : CPB);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_ferr", ferr_a, 0);
    rx_a = 1'b1;
    ready_a = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(120);
    check("mid_no_partial", acc_a - acc0, 0);
    send_frame(0, 8'h81, 0, 0, 1);
    cyc(5);
    check("81_count", acc_a - acc0, 1);
    check("81_data", last_data_a, 8'h81);
    check("81_ferr", last_ferr_a, 0);

    // Even parity on instance b: 0x07 has three ones.
    acc0 = acc_b;
    send_frame(1, 8'h07, 1, 0, 1);
    cyc(5);
    check("par_bad_count", acc_b - acc0, 1);
    check("par_bad_data", last_data_b, 8'h07);
    check("par_bad_perr", last_perr_b, 1);
    check("par_bad_ferr", last_ferr_b, 0);
    send_frame(1, 8'h07, 1, 1, 1);
    cyc(5);
    check("par_ok_count", acc_b - acc0, 2);
    check("par_ok_perr", last_perr_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
